// File: rtl/bcd_pkg.sv
// Shared types and constants for the 10-bit binary to BCD converter.
package bcd_pkg;

  localparam int BIN_W       = 10;
  localparam int ITERACIONES = 10;
  localparam int CNT_W       = 4;
  localparam int NIBBLES     = 4;

  typedef logic [3:0] digito_t;

  typedef enum logic [1:0] {
    INACTIVO,
    DESPLAZA,
    FIN
  } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Single-nibble double-dabble correction: values of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module ajuste_bcd
  import bcd_pkg::*;
(
  input  digito_t entrada,
  output digito_t salida
);

  always_comb begin
    salida = entrada;
    if (entrada >= 4'd5) salida = entrada + 4'd3;
  end

endmodule

// File: rtl/bin_a_bcd.sv
// Iterative shift-add-3 binary to BCD converter: one input bit per clock,
// MSB first, with the four result digits registered only when a run finishes.
module bin_a_bcd
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             n_reset,
  input  logic [BIN_W-1:0] numero,
  input  logic             iniciar,
  output logic [3:0]       millares,
  output logic [3:0]       centenas,
  output logic [3:0]       decenas,
  output logic [3:0]       unidades,
  output logic             ocupado,
  output logic             listo
);

  localparam int REG_W = 4 * NIBBLES + BIN_W;

  estado_t                estado;
  logic [REG_W-1:0]       registro;
  logic [CNT_W-1:0]       cuenta;
  logic [4*NIBBLES-1:0]   ajustado;
  logic [REG_W-1:0]       siguiente;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .entrada (registro[BIN_W + 4*g +: 4]),
      .salida  (ajustado[4*g +: 4])
    );
  end

  // Scratch digits sit above the binary bits so one shift moves the next MSB in.
  assign siguiente = {ajustado, registro[BIN_W-1:0]} << 1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      estado   <= INACTIVO;
      registro <= '0;
      cuenta   <= '0;
      millares <= '0;
      centenas <= '0;
      decenas  <= '0;
      unidades <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (estado)
        INACTIVO, FIN: begin
          if (iniciar) begin
            registro <= {{(4*NIBBLES){1'b0}}, numero};
            cuenta   <= '0;
            ocupado  <= 1'b1;
            estado   <= DESPLAZA;
          end else begin
            estado <= INACTIVO;
          end
        end
        DESPLAZA: begin
          registro <= siguiente;
          cuenta   <= cuenta + 1'b1;
          // The last shift's result goes straight to the outputs on this edge.
          if (cuenta == CNT_W'(ITERACIONES - 1)) begin
            estado   <= FIN;
            ocupado  <= 1'b0;
            listo    <= 1'b1;
            millares <= siguiente[BIN_W + 12 +: 4];
            centenas <= siguiente[BIN_W + 8 +: 4];
            decenas  <= siguiente[BIN_W + 4 +: 4];
            unidades <= siguiente[BIN_W +: 4];
          end
        end
        default: estado <= INACTIVO;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_a_bcd.sv
// Self-checking bench for bin_a_bcd against a decimal-arithmetic reference.
module tb_bin_a_bcd;

  logic       clk;
  logic       n_reset;
  logic [9:0] numero;
  logic       iniciar;
  logic [3:0] millares, centenas, decenas, unidades;
  logic       ocupado, listo;

  int errors = 0;
  int checks = 0;

  bin_a_bcd dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .numero   (numero),
    .iniciar  (iniciar),
    .millares (millares),
    .centenas (centenas),
    .decenas  (decenas),
    .unidades (unidades),
    .ocupado  (ocupado),
    .listo    (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {millares, centenas, decenas, unidades};
  endfunction

  // Drives one conversion and reports what was observed; callers do the judging.
  task automatic convertir(input logic [9:0] valor, output int latencia,
                           output logic [15:0] resultado, output bit ocupado_ok,
                           output bit estable);
    logic [15:0] previo;
    previo     = digits();
    latencia   = -1;
    resultado  = 16'hxxxx;
    ocupado_ok = 1'b1;
    estable    = 1'b1;
    @(posedge clk); #1;
    numero  = valor;
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    numero  = 10'($urandom_range(0, 1023));
    for (int c = 0; c < 30 && latencia < 0; c++) begin
      @(negedge clk);
      if (listo) begin
        latencia  = c;
        resultado = digits();
        if (ocupado) ocupado_ok = 1'b0;
      end else begin
        if (ocupado !== (c < 10)) ocupado_ok = 1'b0;
        if (digits() !== previo) estable = 1'b0;
      end
      if (latencia < 0) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    iniciar = 1'b0;
    numero  = 10'd0;
    #2;
    checks++;
    if ({digits(), ocupado, listo} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_async outputs=%h expected=0", {digits(), ocupado, listo});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({digits(), ocupado, listo} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_held outputs=%h expected=0", {digits(), ocupado, listo});
    end
    n_reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] res;
    bit ok_ocu, ok_hold;
    convertir(10'd213, lat, res, ok_ocu, ok_hold);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("[TB] FAIL basic_latency got=%0d expected=10", lat);
    end
    checks++;
    if (res !== 16'h0213) begin
      errors++;
      $display("[TB] FAIL basic_digits got=%h expected=0213", res);
    end
    checks++;
    if (!ok_ocu) begin
      errors++;
      $display("[TB] FAIL basic_ocupado got=0 expected=1 (window wrong)");
    end
    checks++;
    if (!ok_hold) begin
      errors++;
      $display("[TB] FAIL basic_hold got=0 expected=1 (digits moved mid-run)");
    end
    @(negedge clk);
    checks++;
    if (listo !== 1'b0 || digits() !== 16'h0213) begin
      errors++;
      $display("[TB] FAIL basic_after listo=%b digits=%h expected listo=0 digits=0213", listo, digits());
    end
  endtask

  task automatic test_corners();
    int vals[3] = '{0, 999, 1023};
    int lat;
    logic [15:0] res;
    bit ok_ocu, ok_hold;
    foreach (vals[i]) begin
      convertir(10'(vals[i]), lat, res, ok_ocu, ok_hold);
      checks++;
      if (lat !== 10 || res !== ref_bcd(vals[i]) || !ok_ocu || !ok_hold) begin
        errors++;
        $display("[TB] FAIL corner_%0d got lat=%0d digits=%h ocu=%b hold=%b expected lat=10 digits=%h ocu=1 hold=1",
                 vals[i], lat, res, ok_ocu, ok_hold, ref_bcd(vals[i]));
      end
    end
  endtask

  task automatic test_ignore_restart();
    int pulsos = 0;
    int primero = -1;
    logic [15:0] res = 16'hxxxx;
    @(posedge clk); #1;
    numero  = 10'd500;
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (listo) begin
        pulsos++;
        if (primero < 0) begin
          primero = c;
          res = digits();
        end
      end
      if (c == 3) begin
        iniciar = 1'b1;
        numero  = 10'd7;
      end else begin
        iniciar = 1'b0;
        numero  = 10'($urandom_range(0, 1023));
      end
    end
    checks++;
    if (pulsos !== 1 || primero !== 10) begin
      errors++;
      $display("[TB] FAIL restart_ignored got pulses=%0d first=%0d expected pulses=1 first=10", pulsos, primero);
    end
    checks++;
    if (res !== 16'h0500) begin
      errors++;
      $display("[TB] FAIL restart_digits got=%h expected=0500", res);
    end
  endtask

  task automatic test_reset_abort();
    int pulsos = 0;
    @(posedge clk); #1;
    numero  = 10'd777;
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (listo) pulsos++;
      if (c == 6) begin
        n_reset = 1'b0;
        #1;
        checks++;
        if ({digits(), ocupado, listo} !== 18'd0) begin
          errors++;
          $display("[TB] FAIL abort_async outputs=%h expected=0", {digits(), ocupado, listo});
        end
      end
      if (c == 8) n_reset = 1'b1;
    end
    checks++;
    if (pulsos !== 0 || ocupado !== 1'b0 || digits() !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL abort_after got pulses=%0d ocupado=%b digits=%h expected 0/0/0000", pulsos, ocupado, digits());
    end
  endtask

  task automatic test_back_to_back();
    int ciclo[$];
    logic [15:0] res[$];
    int esperado_ciclo[3] = '{10, 21, 32};
    @(posedge clk); #1;
    numero  = 10'd100;
    iniciar = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (listo) begin
        ciclo.push_back(c);
        res.push_back(digits());
        numero = numero + 10'd1;
        if (ciclo.size() == 3) iniciar = 1'b0;
      end
    end
    iniciar = 1'b0;
    checks++;
    if (ciclo.size() !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_count got=%0d expected=3", ciclo.size());
    end
    for (int i = 0; i < 3 && i < ciclo.size(); i++) begin
      checks++;
      if (ciclo[i] !== esperado_ciclo[i] || res[i] !== ref_bcd(100 + i)) begin
        errors++;
        $display("[TB] FAIL b2b_result_%0d got cycle=%0d digits=%h expected cycle=%0d digits=%h",
                 i, ciclo[i], res[i], esperado_ciclo[i], ref_bcd(100 + i));
      end
    end
  endtask

  task automatic test_random();
    int v, lat;
    logic [15:0] res;
    bit ok_ocu, ok_hold;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 1023);
      convertir(10'(v), lat, res, ok_ocu, ok_hold);
      checks++;
      if (lat !== 10 || res !== ref_bcd(v) || !ok_ocu || !ok_hold) begin
        errors++;
        $display("[TB] FAIL random_%0d got lat=%0d digits=%h ocu=%b hold=%b expected lat=10 digits=%h",
                 v, lat, res, ok_ocu, ok_hold, ref_bcd(v));
      end
    end
  endtask

  task automatic test_sweep();
    int lat;
    logic [15:0] res;
    bit ok_ocu, ok_hold;
    for (int v = 0; v < 1024; v++) begin
      convertir(10'(v), lat, res, ok_ocu, ok_hold);
      checks++;
      if (lat !== 10 || res !== ref_bcd(v)) begin
        errors++;
        $display("[TB] FAIL sweep_%0d got lat=%0d digits=%h expected lat=10 digits=%h", v, lat, res, ref_bcd(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_restart();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
